conv_engine_seq: RTL

//  Parametrised, self-sequenced successor to the fixed single/2x2/3x3 convolution datapaths.

---
 rtl/conv_pkg.sv | 28 ++
 rtl/conv_mac.sv | 30 +++
 rtl/conv_engine_seq.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/conv_pkg.sv
// Shared types and helpers for the sequential convolution engine.
package conv_pkg;

    localparam int CONV_DATA_W = 8;
    localparam int CONV_IN_DIM = 4;
    localparam int CONV_MAX_K  = 3;
    localparam int CONV_OUT_W  = 8;
    localparam int IDX_W       = $clog2(CONV_IN_DIM);
    localparam int KW          = $clog2(CONV_MAX_K + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MAC  = 2'd1,
        OUT  = 2'd2,
        FIN  = 2'd3
    } state_t;

    // Flat element index of image element (r,c) for a dim x dim image.
    function automatic int img_idx(input int r, input int c, input int dim);
        return r * dim + c;
    endfunction

    // Flat element index of filter element (r,c); the filter is stored at MAX_K pitch.
    function automatic int flt_idx(input int r, input int c, input int max_k);
        return r * max_k + c;
    endfunction

endpackage

// File: rtl/conv_mac.sv
// Single multiply-accumulate unit: one unsigned product per enabled cycle.
module conv_mac #(
    parameter int DATA_W = 8,
    parameter int ACC_W  = 2 * DATA_W + 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_en,
    input  logic              i_load,
    input  logic [DATA_W-1:0] i_a,
    input  logic [DATA_W-1:0] i_b,
    output logic [ACC_W-1:0]  o_acc,
    output logic [ACC_W-1:0]  o_acc_nxt
);

    logic [2*DATA_W-1:0] w_prod;
    logic [ACC_W-1:0]    r_acc;

    assign w_prod    = i_a * i_b;
    // The first tap of a pixel replaces the old sum instead of adding to it.
    assign o_acc_nxt = i_load ? ACC_W'(w_prod) : r_acc + ACC_W'(w_prod);
    assign o_acc     = r_acc;

    // Accumulator register, advanced once per enabled tap.
    always_ff @(posedge clk) begin
        if (rst)       r_acc <= '0;
        else if (i_en) r_acc <= o_acc_nxt;
    end

endmodule

// File: rtl/conv_engine_seq.sv
// Self-sequenced KxK convolution over an IN_DIM x IN_DIM image, one MAC,
// stride 1, no padding, results streamed in raster order on valid/ready.
module conv_engine_seq
    import conv_pkg::*;
#(
    parameter int DATA_W = CONV_DATA_W,
    parameter int IN_DIM = CONV_IN_DIM,
    parameter int MAX_K  = CONV_MAX_K,
    parameter int ACC_W  = 2 * DATA_W + 4,
    parameter int OUT_W  = CONV_OUT_W
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             start,
    input  logic [$clog2(MAX_K+1)-1:0]       k_size,
    input  logic [IN_DIM*IN_DIM*DATA_W-1:0]  img_flat,
    input  logic [MAX_K*MAX_K*DATA_W-1:0]    flt_flat,
    output logic                             busy,
    output logic                             done,
    output logic                             err,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [OUT_W-1:0]                 out_data,
    output logic [$clog2(IN_DIM)-1:0]        out_row,
    output logic [$clog2(IN_DIM)-1:0]        out_col,
    output logic                             out_sat
);

    localparam int IW  = $clog2(IN_DIM);
    localparam int KSW = $clog2(MAX_K + 1);
    localparam logic [ACC_W-1:0] SAT_LIM = ACC_W'((2 ** OUT_W) - 1);

    state_t                          r_state;
    logic [IN_DIM*IN_DIM*DATA_W-1:0] r_img;
    logic [MAX_K*MAX_K*DATA_W-1:0]   r_flt;
    logic [KSW-1:0]                  r_k;
    logic [IW-1:0]                   r_r, r_c, r_i, r_j;

    logic [DATA_W-1:0] w_a, w_b;
    logic [ACC_W-1:0]  w_acc, w_acc_nxt;
    logic              w_first_tap, w_last_j, w_last_tap;
    logic              w_last_col, w_last_pix, w_sat, w_k_ok;
    logic [OUT_W-1:0]  w_res;
    int                w_lim;

    // Tap operand mux and position decode.
    always_comb begin
        w_a         = r_img[img_idx(int'(r_r) + int'(r_i), int'(r_c) + int'(r_j), IN_DIM) * DATA_W +: DATA_W];
        w_b         = r_flt[flt_idx(int'(r_i), int'(r_j), MAX_K) * DATA_W +: DATA_W];
        w_lim       = IN_DIM - int'(r_k);
        w_first_tap = (r_i == '0) && (r_j == '0);
        w_last_j    = int'(r_j) == int'(r_k) - 1;
        w_last_tap  = w_last_j && (int'(r_i) == int'(r_k) - 1);
        w_last_col  = int'(r_c) == w_lim;
        w_last_pix  = w_last_col && (int'(r_r) == w_lim);
        w_k_ok      = (k_size != '0) && (int'(k_size) <= MAX_K);
        w_sat       = w_acc_nxt > SAT_LIM;
        w_res       = w_sat ? '1 : w_acc_nxt[OUT_W-1:0];
    end

    conv_mac #(
        .DATA_W (DATA_W),
        .ACC_W  (ACC_W)
    ) u_mac (
        .clk       (clk),
        .rst       (rst),
        .i_en      (r_state == MAC),
        .i_load    (w_first_tap),
        .i_a       (w_a),
        .i_b       (w_b),
        .o_acc     (w_acc),
        .o_acc_nxt (w_acc_nxt)
    );

    // Sequencer: capture job, walk taps per pixel, present result, step pixel.
    // The result is latched from the sum being formed on the last tap edge, so
    // out_valid rises exactly K*K cycles after the accept edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_img     <= '0;
            r_flt     <= '0;
            r_k       <= '0;
            r_r       <= '0;
            r_c       <= '0;
            r_i       <= '0;
            r_j       <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_row   <= '0;
            out_col   <= '0;
            out_sat   <= 1'b0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        if (w_k_ok) begin
                            r_img   <= img_flat;
                            r_flt   <= flt_flat;
                            r_k     <= k_size;
                            r_r     <= '0;
                            r_c     <= '0;
                            r_i     <= '0;
                            r_j     <= '0;
                            busy    <= 1'b1;
                            r_state <= MAC;
                        end else begin
                            err <= 1'b1;
                        end
                    end
                end
                MAC: begin
                    if (w_last_tap) begin
                        r_i       <= '0;
                        r_j       <= '0;
                        out_data  <= w_res;
                        out_sat   <= w_sat;
                        out_row   <= r_r;
                        out_col   <= r_c;
                        out_valid <= 1'b1;
                        r_state   <= OUT;
                    end else if (w_last_j) begin
                        r_j <= '0;
                        r_i <= r_i + 1'b1;
                    end else begin
                        r_j <= r_j + 1'b1;
                    end
                end
                OUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        if (w_last_pix) begin
                            done    <= 1'b1;
                            r_state <= FIN;
                        end else begin
                            if (w_last_col) begin
                                r_c <= '0;
                                r_r <= r_r + 1'b1;
                            end else begin
                                r_c <= r_c + 1'b1;
                            end
                            r_state <= MAC;
                        end
                    end
                end
                FIN: begin
                    busy    <= 1'b0;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule
